// File: rtl/io_pkg.sv
// Shared definitions for the terminal I/O unit.
//   IO_DATA_W        : character width
//   IO_FIFO_DEPTH    : default RX FIFO depth
//   tx_state_t       : output-side state machine encoding
package io_pkg;

  localparam int IO_DATA_W     = 8;
  localparam int IO_FIFO_DEPTH = 4;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_t;

endpackage

// File: rtl/io_rx_fifo.sv
// Circular receive FIFO for incoming terminal characters.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   push, din    : write request and character
//   pop          : consume the head entry
//   dout         : head entry, 0 when empty
//   count        : number of stored entries
//   full, empty  : occupancy flags derived from count
module io_rx_fifo
  import io_pkg::*;
#(
  parameter int DATA_W     = IO_DATA_W,
  parameter int FIFO_DEPTH = IO_FIFO_DEPTH
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_W-1:0]             din,
  output logic [DATA_W-1:0]             dout,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  // Requests against a full/empty FIFO are dropped here as a second guard.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_port_unit.sv
// Terminal I/O responder serving INP, OUT, SKI, SKO and the interrupt check.
// Ports:
//   clock, reset         : system clock, synchronous active-high reset
//   AC_low, OUTR_load    : OUT source character and load pulse
//   INP_ack              : INP pulse, consumes INPR
//   IEN_out              : interrupt enable from the CPU
//   INPR, FGI            : RX head character and input flag
//   FGO, tx_overrun      : output-free flag and sticky overrun flag
//   irq                  : IEN_out & (FGI | FGO)
//   rx_data/valid/ready  : terminal-side input stream
//   tx_data/valid/ready  : terminal-side output stream
module io_port_unit
  import io_pkg::*;
#(
  parameter int DATA_W     = IO_DATA_W,
  parameter int FIFO_DEPTH = IO_FIFO_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] AC_low,
  input  logic              OUTR_load,
  input  logic              INP_ack,
  input  logic              IEN_out,
  output logic [DATA_W-1:0] INPR,
  output logic              FGI,
  output logic              FGO,
  output logic              irq,
  output logic              tx_overrun,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [CNT_W-1:0] rx_count;
  logic             rx_full;
  logic             rx_empty;
  logic             rx_push;
  logic             rx_pop;
  tx_state_t        tx_state;
  logic [DATA_W-1:0] outr;

  // rx_ready depends only on the registered count, never on INP_ack.
  assign rx_ready = (rx_count != CNT_W'(FIFO_DEPTH));
  assign rx_push  = rx_valid & ~rx_full;
  assign FGI      = ~rx_empty;
  assign rx_pop   = INP_ack & FGI;
  assign irq      = IEN_out & (FGI | FGO);
  assign tx_data  = outr;

  io_rx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_data),
    .dout  (INPR),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // FGO and tx_valid are registered alongside the state so they never glitch.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state   <= TX_IDLE;
      outr       <= '0;
      FGO        <= 1'b1;
      tx_valid   <= 1'b0;
      tx_overrun <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (OUTR_load) begin
            outr     <= AC_low;
            tx_state <= TX_BUSY;
            FGO      <= 1'b0;
            tx_valid <= 1'b1;
          end
        end
        TX_BUSY: begin
          // A load here is lost even in the accept cycle, since FGO is still 0.
          if (OUTR_load) tx_overrun <= 1'b1;
          if (tx_ready) begin
            tx_state <= TX_IDLE;
            FGO      <= 1'b1;
            tx_valid <= 1'b0;
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          FGO      <= 1'b1;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/io_port_unit.md
# io_port_unit

Terminal I/O responder for the basic computer. It serves the accumulator-side I/O instructions issued by the hardwired controller: INP, OUT, SKI, SKO and the interrupt check. It buffers incoming characters from an external producer in a small FIFO and presents the head as INPR with the FGI flag. It holds one outgoing character in OUTR, drives it to an external consumer, and reports completion through FGO. It sits between the CPU datapath/controller and the terminal-side streaming interfaces.

## Interface
- DATA_W, 8, character width (INPR/OUTR/AC low bits)
- FIFO_DEPTH, 4, RX FIFO entries; power of two, ≥2

- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- AC_low  in  DATA_W  accumulator low bits, OUT source
- OUTR_load  in  1  one-cycle pulse, CPU executes OUT
- INP_ack  in  1  one-cycle pulse, CPU executes INP (consumes INPR)
- IEN_out  in  1  interrupt enable flip-flop from CPU
- INPR  out  DATA_W  head of RX FIFO; 0 when empty
- FGI  out  1  input flag, 1 = character available
- FGO  out  1  output flag, 1 = OUTR free
- irq  out  1  IEN_out & (FGI | FGO), combinational
- tx_overrun  out  1  sticky: OUTR_load arrived while FGO=0
- rx_data  in  DATA_W  external input character
- rx_valid  in  1  producer has a character
- rx_ready  out  1  FIFO not full
- tx_data  out  DATA_W  OUTR contents
- tx_valid  out  1  OUTR holds an undelivered character
- tx_ready  in  1  consumer accepts

## Operation
- RX path: circular FIFO, write pointer, read pointer and count, all registered. Push when rx_valid & rx_ready. Pop when INP_ack & FGI.
- FGI = (count != 0). INPR = mem[rd_ptr] when count != 0, else 0.
- rx_ready = (count != FIFO_DEPTH), driven from registered count only. There is no combinational path from INP_ack.
- Simultaneous push and pop: count unchanged and both pointers advance. When full, rx_ready=0, so a push cannot coincide with a full FIFO.
- INP_ack while FGI=0: ignored, no state change.
- Pointers wrap modulo FIFO_DEPTH. count width is clog2(FIFO_DEPTH)+1.
- TX state machine, two states:
  - IDLE: FGO=1, tx_valid=0. OUTR_load loads OUTR←AC_low and moves to BUSY.
  - BUSY: FGO=0, tx_valid=1, tx_data=OUTR stable. tx_valid & tx_ready moves to IDLE.
- OUTR_load in BUSY: ignored, OUTR unchanged, tx_overrun←1. This includes the cycle in which tx_ready completes the transfer, because FGO is still 0 in that cycle.
- tx_overrun is cleared only by reset.
- Reset values: FIFO empty, pointers 0, FGI=0, INPR=0, rx_ready=1, state IDLE, FGO=1, tx_valid=0, OUTR=0, tx_data=0, tx_overrun=0.
- Reset mid-operation: the FIFO contents are discarded, and an undelivered OUTR character is dropped with tx_valid falling on the next edge.

## Timing
- RX push at edge N: FGI and INPR valid after edge N (same cycle as count update). Latency 1 cycle.
- INP_ack at edge N: INPR shows the next entry, or FGI falls, after edge N.
- OUTR_load at edge N: tx_valid=1, FGO=0 after edge N.
- Accept (tx_valid & tx_ready) at edge M: FGO=1, tx_valid=0 after edge M. The earliest next OUTR_load is accepted at edge M+1.
- Full throughput: one RX character per cycle while not full. One TX character per 2 cycles (load, accept).
- irq follows the flags with no added latency.

## Structure
- Shared package io_pkg holds:
  - IO_DATA_W = 8 and the default FIFO_DEPTH
  - the TX state enum (TX_IDLE, TX_BUSY)
- Sub-module io_rx_fifo (parameters DATA_W, FIFO_DEPTH; ports push, pop, din, dout, count, full, empty). Instantiated once.
- TX state machine and flag logic stay in io_port_unit.

## Test plan
- Reset then idle: FGI=0, FGO=1, rx_ready=1, tx_valid=0, INPR=0, irq=0; with IEN_out=1, irq=1 (from FGO).
- Push 0x41, 0x42, 0x43, 0x44 back-to-back: rx_ready falls after the 4th push. A 5th rx_valid with 0x45 is not accepted. Four INP_ack pulses read 0x41..0x44 in order, then FGI=0.
- FIFO at count 2, push 0x55 and INP_ack in the same cycle: count stays 2, INPR advances, 0x55 is read last.
- OUTR_load with AC_low=0x5A, tx_ready held 0 for 3 cycles: tx_data=0x5A and tx_valid=1 held stable, FGO=0. Raise tx_ready: FGO=1 one cycle later.
- OUTR_load with 0x11 in BUSY: tx_data stays at the first character and tx_overrun=1. The next OUTR_load after FGO=1 is accepted normally.
- Reset asserted with 3 RX entries and TX BUSY: next cycle FIFO empty, FGI=0, FGO=1, tx_valid=0, tx_overrun=0.
